// File: rtl/nnrv_uart_loader.sv
// UART (8N1) boot loader: receives an A5-headed, length-prefixed image and writes it
// into the nnRv instruction/data RAM one 32-bit word at a time, holding the core in reset.
//
// state      | meaning
// LD_IDLE    | waiting for header byte 0xA5, other bytes dropped
// LD_CNT_LO  | next byte is word count N[7:0]
// LD_CNT_HI  | next byte is word count N[15:8], range-checked
// LD_DATA    | collecting little-endian bytes, one RAM write per 4 bytes
// LD_DONE    | image complete, core released, RXD ignored
// LD_ERR     | protocol/framing error, core held, wait for RST_N
module nnrv_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RXD,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      N_MAX    = 17'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_IDLE, LD_CNT_LO, LD_CNT_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, byte_err;

  ld_state_t         ld_state_q, ld_state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_sel_q, byte_sel_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_rst_n_q, cpu_rst_n_d;
  logic [15:0]       n_hdr;
  logic [16:0]       idx_ext;

  // Bit timer reloads on every sample; start bit is checked half a bit in.
  always_comb begin
    rx_state_d = rx_state_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          tmr_d      = TMR_HALF;
        end
      end
      RX_START: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (!rxd_s2_q) begin
          rx_state_d = RX_DATA;
          tmr_d      = TMR_FULL;
          bit_cnt_d  = 3'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          tmr_d      = TMR_FULL;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          byte_valid = rxd_s2_q;
          byte_err   = !rxd_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_state_d  = ld_state_q;
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    byte_sel_d  = byte_sel_q;
    word_buf_d  = word_buf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    n_hdr       = {rx_shift_q, cnt_q[7:0]};
    idx_ext     = 17'(word_idx_q);
    if (byte_err && ld_state_q != LD_DONE && ld_state_q != LD_ERR) begin
      ld_state_d = LD_ERR;
      err_d      = 1'b1;
      busy_d     = 1'b0;
    end else begin
      unique case (ld_state_q)
        LD_IDLE: begin
          if (byte_valid && rx_shift_q == 8'hA5) begin
            ld_state_d = LD_CNT_LO;
            busy_d     = 1'b1;
          end
        end
        LD_CNT_LO: begin
          if (byte_valid) begin
            cnt_d[7:0] = rx_shift_q;
            ld_state_d = LD_CNT_HI;
          end
        end
        LD_CNT_HI: begin
          if (byte_valid) begin
            if (n_hdr == 16'd0 || {1'b0, n_hdr} > N_MAX) begin
              ld_state_d = LD_ERR;
              err_d      = 1'b1;
              busy_d     = 1'b0;
            end else begin
              cnt_d      = n_hdr;
              word_idx_d = '0;
              byte_sel_d = 2'd0;
              ld_state_d = LD_DATA;
            end
          end
        end
        LD_DATA: begin
          // Completion is seen one cycle after the final strobe so the write lands first.
          if (idx_ext == {1'b0, cnt_q}) begin
            ld_state_d  = LD_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            cpu_rst_n_d = 1'b1;
          end else if (byte_valid) begin
            if (byte_sel_q == 2'd3) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = word_idx_q[ADDR_W-1:0];
              wr_data_d  = {rx_shift_q, word_buf_q};
              word_idx_d = word_idx_q + 1'b1;
              byte_sel_d = 2'd0;
            end else begin
              word_buf_d = {rx_shift_q, word_buf_q[23:8]};
              byte_sel_d = byte_sel_q + 2'd1;
            end
          end
        end
        LD_DONE, LD_ERR: ;
        default: ld_state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'd0;
      ld_state_q  <= LD_IDLE;
      cnt_q       <= 16'd0;
      word_idx_q  <= '0;
      byte_sel_q  <= 2'd0;
      word_buf_q  <= 24'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      rxd_s1_q    <= RXD;
      rxd_s2_q    <= rxd_s1_q;
      rxd_prev_q  <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      ld_state_q  <= ld_state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_sel_q  <= byte_sel_d;
      word_buf_q  <= word_buf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_nnrv_uart_loader.sv
// Bench for nnrv_uart_loader: directed and random byte streams scored against a
// stream-level model of the expected RAM writes and final status flags.
module tb_nnrv_uart_loader;
  localparam int CPB = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst_n, busy, done, err;

  nnrv_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .CLK(clk), .RST_N(rst_n), .RXD(rxd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int last_wr_cyc = -1;
  int done_cyc = -1;
  int cpu_cyc = -1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(32'(wr_addr));
      got_data.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (cpu_rst_n === 1'b1 && cpu_cyc < 0) cpu_cyc = cyc;
  end

  logic [31:0] m_words[$];
  bit m_done, m_err, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome from the stream as a whole: header position, count, and how many
  // complete words precede any framing error. Bit 8 of a stream entry marks a bad stop bit.
  task automatic model(input logic [8:0] s[$]);
    int k, n, base, avail, bad, nw;
    m_words.delete();
    m_done = 0; m_err = 0; m_busy = 0;
    k = -1;
    for (int i = 0; i < s.size(); i++)
      if (s[i][8] || s[i][7:0] == 8'hA5) begin k = i; break; end
    if (k < 0) return;
    if (s[k][8]) begin m_err = 1; return; end
    for (int j = 1; j <= 2; j++) begin
      if (k + j >= s.size()) begin m_busy = 1; return; end
      if (s[k+j][8]) begin m_err = 1; return; end
    end
    n = int'(s[k+1][7:0]) + 256 * int'(s[k+2][7:0]);
    if (n == 0 || n > (1 << AW)) begin m_err = 1; return; end
    base = k + 3;
    avail = s.size() - base;
    if (avail > 4 * n) avail = 4 * n;
    bad = -1;
    for (int j = 0; j < avail; j++)
      if (s[base+j][8]) begin bad = j; break; end
    nw = (bad >= 0) ? bad / 4 : avail / 4;
    for (int w = 0; w < nw; w++)
      m_words.push_back({s[base+4*w+3][7:0], s[base+4*w+2][7:0],
                         s[base+4*w+1][7:0], s[base+4*w][7:0]});
    if (bad >= 0) m_err = 1;
    else if (avail == 4 * n) m_done = 1;
    else m_busy = 1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [8:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(!b[8]);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_stream(input logic [8:0] s[$]);
    for (int i = 0; i < s.size(); i++) send_byte(s[i]);
    repeat (30) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".wr_data"}, wr_data, 32'd0);
    chk({tag, ".flags"}, {28'd0, cpu_rst_n, busy, done, err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd = 1'(i);
      @(negedge clk);
    end
    rxd = 1'b1;
    rst_n = 1'b1;
    got_addr.delete();
    got_data.delete();
    last_wr_cyc = -1; done_cyc = -1; cpu_cyc = -1;
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string name);
    int nmin;
    chk({name, ".nwr"}, 32'(got_data.size()), 32'(m_words.size()));
    nmin = (got_data.size() < m_words.size()) ? got_data.size() : m_words.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s.addr%0d", name, i), got_addr[i], 32'(i));
      chk($sformatf("%s.data%0d", name, i), got_data[i], m_words[i]);
    end
    chk({name, ".done"}, 32'(done), 32'(m_done));
    chk({name, ".err"}, 32'(err), 32'(m_err));
    chk({name, ".busy"}, 32'(busy), 32'(m_busy));
    chk({name, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(m_done));
    if (m_done && got_data.size() > 0) begin
      chk({name, ".done_lat"}, 32'(done_cyc - last_wr_cyc), 32'd1);
      chk({name, ".cpu_lat"}, 32'(cpu_cyc - last_wr_cyc), 32'd1);
    end
  endtask

  task automatic run_case(input string name, input logic [8:0] s[$]);
    do_reset();
    send_stream(s);
    model(s);
    compare(name);
  endtask

  initial begin
    logic [8:0] s[$];
    logic [7:0] b;
    int nj, n, idx;

    // Reset held with RXD toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd = 1'(i);
      @(negedge clk);
    end
    check_reset_vals("reset");
    chk("reset.nwr", 32'(got_data.size()), 32'd0);

    s = '{9'h0A5, 9'h002, 9'h000, 9'h078, 9'h056, 9'h034, 9'h012,
          9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE};
    run_case("load2", s);
    chk("load2.w1_const", got_data.size() > 1 ? got_data[1] : 32'hX, 32'hDEADBEEF);

    s = '{9'h000, 9'h0FF, 9'h03C, 9'h0A5, 9'h001, 9'h000, 9'h001, 9'h000, 9'h000, 9'h000};
    run_case("junk", s);

    s = '{9'h0A5, 9'h001, 9'h004, 9'h0A5, 9'h001, 9'h000, 9'h011, 9'h022, 9'h033, 9'h044};
    run_case("badcnt", s);

    s = '{9'h0A5, 9'h000, 9'h000, 9'h0A5, 9'h001, 9'h000, 9'h011, 9'h022, 9'h033, 9'h044};
    run_case("zerocnt", s);

    s = '{9'h0A5, 9'h001, 9'h000, 9'h155};
    run_case("frame", s);

    s = '{9'h100, 9'h0A5, 9'h001, 9'h000, 9'h011, 9'h022, 9'h033, 9'h044};
    run_case("frame_idle", s);

    // Glitch, then reset in the middle of a word.
    do_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch.flags", {30'd0, busy, err}, 32'd0);
    chk("glitch.nwr", 32'(got_data.size()), 32'd0);
    s = '{9'h0A5, 9'h002, 9'h000, 9'h011, 9'h022};
    send_stream(s);
    chk("midload.busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    s = '{9'h0A5, 9'h001, 9'h000, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
    send_stream(s);
    model(s);
    compare("after_reset");

    for (int r = 0; r < 5; r++) begin
      s.delete();
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        s.push_back({1'b0, b});
      end
      n = $urandom_range(1, 3);
      s.push_back(9'h0A5);
      s.push_back(9'(n));
      s.push_back(9'h000);
      for (int j = 0; j < 4 * n; j++) s.push_back({1'b0, 8'($urandom_range(0, 255))});
      if (r == 4) s.push_back({1'b0, 8'($urandom_range(0, 255))});
      if (r >= 3) begin
        idx = $urandom_range(0, s.size() - 1);
        s[idx][8] = 1'b1;
      end
      run_case($sformatf("rand%0d", r), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
